bk16_add_arbiter: RTL
=====================

BK16_ADD_ARBITER -- requirements
Module: bk16_add_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter: IDW, 2, requester-id width, equal to ceil(log2(NREQ)).
REQ-003 Port: clk  input  1  single clock, all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: req_valid  input  NREQ  per-requester operand-valid.
REQ-006 Port: req_ready  output  NREQ  per-requester accept strobe, one-hot or zero.
REQ-007 Port: req_a  input  16*NREQ  operand A, requester i in bits [16i+15:16i].
REQ-008 Port: req_b  input  16*NREQ  operand B, same packing as req_a.
REQ-009 Port: rsp_valid  output  1  result-valid.
REQ-010 Port: rsp_ready  input  1  consumer ready.
REQ-011 Port: rsp_sum  output  17  unsigned sum, bit 16 is the carry-out.
REQ-012 Port: rsp_id  output  IDW  index of the requester owning rsp_sum.
REQ-013 Port: txn_count  output  16  number of accepted requests, modulo 2^16.

Function
REQ-014 The block SHALL contain exactly one BK_16b instance, fed only from the stage-1 operand registers.
REQ-015 Pipeline: stage 1 holds s1_valid/a/b/id; stage 2 holds rsp_valid/rsp_sum/rsp_id.
REQ-016 Transfer rules:
- adv2 = !rsp_valid | rsp_ready.
- adv1 = !s1_valid | adv2.
REQ-017 Grant: when adv1=1, req_ready SHALL be one-hot at the first requester with req_valid=1, searching from ptr upward with wrap-around; otherwise req_ready SHALL be 0.
REQ-018 req_ready SHALL never be asserted for a requester whose req_valid is 0.
REQ-019 On an accept edge (req_valid[i] & req_ready[i]), stage 1 SHALL load the operands of requester i and id=i, and set s1_valid=1.
REQ-020 On an accept of requester i, ptr SHALL become (i+1) mod NREQ; with no accept, ptr SHALL hold.
REQ-021 When adv1=1 and nothing is accepted, s1_valid SHALL become 0.
REQ-022 On an edge with adv2=1:
- rsp_valid SHALL be set to s1_valid.
- rsp_sum and rsp_id SHALL load the adder output and s1 id when s1_valid=1.
REQ-023 When rsp_valid=1 and rsp_ready=0, rsp_sum and rsp_id SHALL hold stable.
REQ-024 Latency: a request accepted at edge k SHALL appear on rsp_* after edge k+1 when no stall occurs.
REQ-025 Throughput: with rsp_ready=1, the block SHALL sustain one accept and one response per cycle.
REQ-026 Capacity: at most 2 requests SHALL be in flight; with both stages full and rsp_ready=0, all req_ready SHALL be 0.
REQ-027 Ordering: responses SHALL leave in acceptance order, with none dropped or duplicated.
REQ-028 Simultaneous events: a response drain and a new accept in the same cycle SHALL both complete in that cycle.
REQ-029 rsp_sum SHALL be the full 17-bit sum a+b with no truncation (0xFFFF+0xFFFF=0x1FFFE).
REQ-030 txn_count SHALL increment by 1 per accept and wrap from 0xFFFF to 0x0000.

Reset
REQ-031 While rst=1 at an edge:
- s1_valid, rsp_valid, rsp_sum, rsp_id, ptr and txn_count SHALL clear to 0.
- req_ready SHALL be 0 during that cycle.
REQ-032 Reset mid-operation SHALL discard all in-flight requests; no stale response SHALL appear after rst deasserts.
REQ-033 The first grant after reset SHALL search from requester 0.

Verification
REQ-034 Req0 only, a=0xFFFF, b=0x0001, accept at edge k -> rsp_valid=1 after edge k+1, rsp_sum=0x10000, rsp_id=0, txn_count=1.
REQ-035 All 4 req_valid held high from reset, rsp_ready=1, distinct operands per requester -> grants 0,1,2,3,0,... one per cycle, responses back-to-back in the same order, each with the correct sum.
REQ-036 Continuous stream, rsp_ready=0 for 3 cycles -> rsp_sum/rsp_id held stable, req_ready=0 once 2 requests are in flight, no loss or reordering after release.
REQ-037 Req1 and req3 continuously valid -> grant sequence 1,3,1,3,...; req0 and req2 are never granted.
REQ-038 rst pulsed with both stages full -> next cycle rsp_valid=0, txn_count=0, and the first grant goes to the lowest valid index.
REQ-039 65536 accepts -> txn_count=0x0000; one more accept -> txn_count=0x0001.

Source files
------------

// File: rtl/bk16_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bk16_add_arbiter
// Purpose  : Round-robin arbiter sharing one 16-bit Brent-Kung adder between
//            NREQ requesters through a two-stage valid/ready pipeline.
// Revision : 1.0  initial release
// ============================================================================

module BK_16b (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [16:0] o_sum
);
    logic [15:0] w_x;
    logic [15:0] w_g;
    logic [15:0] w_p;

    // Prefix tree built in place: up-sweep forms power-of-two spans, down-sweep fills the gaps.
    always_comb begin
        w_x = i_a ^ i_b;
        w_g = i_a & i_b;
        w_p = w_x;
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 16; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                    w_p[i] = w_p[i] & w_p[i - (1 << l)];
                end
            end
        end
        for (int l = 2; l >= 0; l--) begin
            for (int i = 0; i < 16; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                    w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                end
            end
        end
    end

    assign o_sum = {w_g[15], w_x[15:1] ^ w_g[14:0], w_x[0]};
endmodule

module bk16_add_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [16:0]          rsp_sum,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          txn_count
);
    localparam logic [IDW-1:0] c_LAST = IDW'(NREQ - 1);

    logic            r_s1_valid;
    logic [15:0]     r_s1_a;
    logic [15:0]     r_s1_b;
    logic [IDW-1:0]  r_s1_id;
    logic            r_rsp_valid;
    logic [16:0]     r_rsp_sum;
    logic [IDW-1:0]  r_rsp_id;
    logic [IDW-1:0]  r_ptr;
    logic [15:0]     r_txn_count;

    logic            w_adv1;
    logic            w_adv2;
    logic            w_accept;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_scan;
    logic [IDW-1:0]  w_gnt_id;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [15:0]     w_a;
    logic [15:0]     w_b;
    logic [16:0]     w_bk_sum;

    assign w_adv2 = !r_rsp_valid || rsp_ready;
    assign w_adv1 = !r_s1_valid || w_adv2;

    // Walk the requesters starting at r_ptr, wrapping at NREQ-1; first valid wins.
    always_comb begin
        w_grant = '0;
        w_scan  = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if ((w_grant == '0) && req_valid[w_scan]) begin
                w_grant[w_scan] = 1'b1;
            end
            w_scan = (w_scan == c_LAST) ? '0 : w_scan + IDW'(1);
        end
    end

    assign req_ready = (w_adv1 && !rst) ? w_grant : '0;
    assign w_accept  = |req_ready;

    always_comb begin
        w_a      = '0;
        w_b      = '0;
        w_gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                w_a      = req_a[16*i +: 16];
                w_b      = req_b[16*i +: 16];
                w_gnt_id = IDW'(i);
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_id == c_LAST) ? '0 : w_gnt_id + IDW'(1);

    BK_16b u_bk (
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_sum (w_bk_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
            r_ptr       <= '0;
            r_txn_count <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= w_accept;
            end
            if (w_accept) begin
                r_s1_a      <= w_a;
                r_s1_b      <= w_b;
                r_s1_id     <= w_gnt_id;
                r_ptr       <= w_ptr_nxt;
                r_txn_count <= r_txn_count + 16'd1;
            end
            if (w_adv2) begin
                r_rsp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_rsp_sum <= w_bk_sum;
                    r_rsp_id  <= r_s1_id;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
    assign txn_count = r_txn_count;
endmodule

`default_nettype wire
